// File: rtl/wordle_pkg.sv
// Shared constants, colour codes, FSM encoding and board addressing for the
// wordle board controller.
package wordle_pkg;

   localparam int ROWS = 6;
   localparam int COLS = 5;

   localparam logic [4:0] BLANK     = 5'd26;
   localparam logic [4:0] KEY_ENTER = 5'd26;
   localparam logic [4:0] KEY_BACK  = 5'd27;

   localparam logic [1:0] COL_GRAY   = 2'd0;
   localparam logic [1:0] COL_GREEN  = 2'd1;
   localparam logic [1:0] COL_YELLOW = 2'd2;
   localparam logic [1:0] COL_PEND   = 2'd3;

   localparam logic [6:0]   CELL_BLANK = {COL_GRAY, BLANK};
   localparam logic [209:0] BOARD_RST  = {30{CELL_BLANK}};

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INPUT,
      ST_SCORE_G,
      ST_SCORE_Y,
      ST_CHECK,
      ST_WON,
      ST_LOST
   } state_t;

   // Bit offset of cell (r,c) inside the 210-bit display image.
   function automatic logic [7:0] cell_idx(input logic [2:0] r, input logic [2:0] c);
      return 8'(35 * int'(r) + 7 * int'(c));
   endfunction

endpackage

// File: rtl/wordle_board_ctrl_if.sv
// Keyboard/word-selector inputs and VGA-facing board outputs of the controller.
interface wordle_board_ctrl_if;
   logic         new_game;
   logic [24:0]  secret;
   logic         key_valid;
   logic [4:0]   key_code;
   logic [209:0] display;
   logic         busy;
   logic         won;
   logic         lost;
   logic [2:0]   cur_row;
   logic [2:0]   cur_col;

   modport master (
      output new_game, secret, key_valid, key_code,
      input  display, busy, won, lost, cur_row, cur_col
   );

   modport slave (
      input  new_game, secret, key_valid, key_code,
      output display, busy, won, lost, cur_row, cur_col
   );
endinterface

// File: rtl/wordle_match_find.sv
// Finds the lowest not-yet-consumed secret position holding a given letter.
module wordle_match_find
   import wordle_pkg::*;
(
   input  logic [4:0]  letter,
   input  logic [24:0] secret,
   input  logic [4:0]  used,
   output logic        hit,
   output logic [2:0]  idx
);

   logic [4:0][4:0] sec_w;
   assign sec_w = secret;

   // Scan downwards so the last assignment wins with the lowest index.
   always_comb begin
      hit = 1'b0;
      idx = 3'd0;
      for (int j = COLS - 1; j >= 0; j--) begin
         if (!used[3'(j)] && sec_w[3'(j)] == letter) begin
            hit = 1'b1;
            idx = 3'(j);
         end
      end
   end

endmodule

// File: rtl/wordle_board_ctrl.sv
// Owns the board image: edits the active row from key strobes, scores guesses
// against the latched secret in a fixed 11-cycle sequence and tracks win/lose.
//
// state      | meaning
// ST_IDLE    | after reset, waiting for new_game, keys ignored
// ST_INPUT   | editing the active row
// ST_SCORE_G | exact-position pass, one column per cycle
// ST_SCORE_Y | present-elsewhere pass, one column per cycle
// ST_CHECK   | publish row colours, decide won / lost / next row
// ST_WON     | terminal, all green
// ST_LOST    | terminal, last row scored without a win
module wordle_board_ctrl
   import wordle_pkg::*;
(
   input  logic dclk,
   input  logic clr,
   wordle_board_ctrl_if.slave bus
);

   state_t       state_q, state_nxt;
   logic [2:0]   pos_q;
   logic [2:0]   cur_row_q, cur_col_q;
   logic [4:0]   guess_q [COLS];
   logic [1:0]   colr_q  [COLS];
   logic [24:0]  secret_q;
   logic [4:0]   used_q;
   logic [209:0] board_q;
   logic         busy_q, won_q, lost_q;

   logic         all_green;
   logic         y_hit;
   logic [2:0]   y_idx;
   logic [4:0]   g_let;
   logic [4:0]   pos_lsb;
   logic         is_letter;

   assign g_let     = guess_q[pos_q];
   assign pos_lsb   = 5'(pos_q) * 5'd5;
   assign is_letter = bus.key_code < BLANK;

   always_comb begin
      all_green = 1'b1;
      for (int i = 0; i < COLS; i++) begin
         if (colr_q[3'(i)] != COL_GREEN) all_green = 1'b0;
      end
   end

   wordle_match_find u_find (
      .letter (g_let),
      .secret (secret_q),
      .used   (used_q),
      .hit    (y_hit),
      .idx    (y_idx)
   );

   always_ff @(posedge dclk or posedge clr) begin
      if (clr) state_q <= ST_IDLE;
      else     state_q <= state_nxt;
   end

   always_comb begin
      state_nxt = state_q;
      if (bus.new_game) begin
         state_nxt = ST_INPUT;
      end else begin
         case (state_q)
            ST_INPUT:
               if (bus.key_valid && bus.key_code == KEY_ENTER && cur_col_q == 3'd5)
                  state_nxt = ST_SCORE_G;
            ST_SCORE_G: if (pos_q == 3'd4) state_nxt = ST_SCORE_Y;
            ST_SCORE_Y: if (pos_q == 3'd4) state_nxt = ST_CHECK;
            ST_CHECK: begin
               if (all_green)                          state_nxt = ST_WON;
               else if (cur_row_q == 3'(ROWS - 1))     state_nxt = ST_LOST;
               else                                    state_nxt = ST_INPUT;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge dclk or posedge clr) begin
      if (clr) begin
         board_q   <= BOARD_RST;
         secret_q  <= '0;
         used_q    <= '0;
         pos_q     <= '0;
         cur_row_q <= '0;
         cur_col_q <= '0;
         busy_q    <= 1'b0;
         won_q     <= 1'b0;
         lost_q    <= 1'b0;
         for (int i = 0; i < COLS; i++) begin
            guess_q[3'(i)] <= '0;
            colr_q[3'(i)]  <= COL_GRAY;
         end
      end else if (bus.new_game) begin
         board_q   <= BOARD_RST;
         secret_q  <= bus.secret;
         used_q    <= '0;
         pos_q     <= '0;
         cur_row_q <= '0;
         cur_col_q <= '0;
         busy_q    <= 1'b0;
         won_q     <= 1'b0;
         lost_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_INPUT: begin
               if (bus.key_valid) begin
                  if (is_letter && cur_col_q < 3'd5) begin
                     board_q[cell_idx(cur_row_q, cur_col_q) +: 7] <= {COL_PEND, bus.key_code};
                     cur_col_q <= cur_col_q + 3'd1;
                  end else if (bus.key_code == KEY_BACK && cur_col_q != 3'd0) begin
                     board_q[cell_idx(cur_row_q, cur_col_q - 3'd1) +: 7] <= CELL_BLANK;
                     cur_col_q <= cur_col_q - 3'd1;
                  end else if (bus.key_code == KEY_ENTER && cur_col_q == 3'd5) begin
                     for (int i = 0; i < COLS; i++) begin
                        guess_q[3'(i)] <= board_q[cell_idx(cur_row_q, 3'(i)) +: 5];
                        colr_q[3'(i)]  <= COL_GRAY;
                     end
                     used_q <= '0;
                     pos_q  <= '0;
                     busy_q <= 1'b1;
                  end
               end
            end
            ST_SCORE_G: begin
               if (g_let == secret_q[pos_lsb +: 5]) begin
                  colr_q[pos_q] <= COL_GREEN;
                  used_q[pos_q] <= 1'b1;
               end else begin
                  colr_q[pos_q] <= COL_GRAY;
               end
               pos_q <= (pos_q == 3'd4) ? 3'd0 : pos_q + 3'd1;
            end
            ST_SCORE_Y: begin
               if (colr_q[pos_q] != COL_GREEN && y_hit) begin
                  colr_q[pos_q] <= COL_YELLOW;
                  used_q[y_idx] <= 1'b1;
               end
               pos_q <= (pos_q == 3'd4) ? 3'd0 : pos_q + 3'd1;
            end
            ST_CHECK: begin
               for (int i = 0; i < COLS; i++)
                  board_q[cell_idx(cur_row_q, 3'(i)) + 8'd5 +: 2] <= colr_q[3'(i)];
               busy_q <= 1'b0;
               if (all_green) begin
                  won_q <= 1'b1;
               end else if (cur_row_q == 3'(ROWS - 1)) begin
                  lost_q <= 1'b1;
               end else begin
                  cur_row_q <= cur_row_q + 3'd1;
                  cur_col_q <= 3'd0;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.display = board_q;
   assign bus.busy    = busy_q;
   assign bus.won     = won_q;
   assign bus.lost    = lost_q;
   assign bus.cur_row = cur_row_q;
   assign bus.cur_col = cur_col_q;

endmodule

// File: tb/tb_wordle_board_ctrl.sv
// Self-checking bench for wordle_board_ctrl: directed scenarios plus random
// games compared against a letter-count scoring model.
module tb_wordle_board_ctrl;
   import wordle_pkg::*;

   logic dclk = 1'b0;
   logic clr  = 1'b1;
   always #5 dclk = ~dclk;

   wordle_board_ctrl_if bus();

   wordle_board_ctrl dut (
      .dclk (dclk),
      .clr  (clr),
      .bus  (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [209:0] RST_IMG = {30{7'h1A}};

   // phase: 0 idle, 1 input, 2 scoring, 3 won, 4 lost
   int m_phase, m_row, m_col;
   int m_let [6][5];
   int m_clr [6][5];
   int m_sec [5];
   bit m_won, m_lost;

   task automatic m_clear_board();
      for (int r = 0; r < 6; r++)
         for (int c = 0; c < 5; c++) begin
            m_let[r][c] = 26;
            m_clr[r][c] = 0;
         end
      m_row = 0; m_col = 0; m_won = 0; m_lost = 0;
   endtask

   task automatic m_new(input logic [24:0] sec);
      m_clear_board();
      for (int i = 0; i < 5; i++) m_sec[i] = int'(sec[5*i +: 5]);
      m_phase = 1;
   endtask

   task automatic m_key(input int k);
      if (m_phase != 1) return;
      if (k < 26 && m_col < 5) begin
         m_let[m_row][m_col] = k; m_clr[m_row][m_col] = 3; m_col++;
      end else if (k == 27 && m_col > 0) begin
         m_col--; m_let[m_row][m_col] = 26; m_clr[m_row][m_col] = 0;
      end else if (k == 26 && m_col == 5) begin
         m_phase = 2;
      end
   endtask

   // Standard two-pass scoring with a per-letter count of unmatched secret letters.
   task automatic m_score();
      int cnt [26];
      int col [5];
      int greens;
      foreach (cnt[i]) cnt[i] = 0;
      greens = 0;
      for (int i = 0; i < 5; i++) begin
         if (m_let[m_row][i] == m_sec[i]) begin col[i] = 1; greens++; end
         else begin col[i] = 0; cnt[m_sec[i]]++; end
      end
      for (int i = 0; i < 5; i++)
         if (col[i] != 1 && cnt[m_let[m_row][i]] > 0) begin
            col[i] = 2; cnt[m_let[m_row][i]]--;
         end
      for (int i = 0; i < 5; i++) m_clr[m_row][i] = col[i];
      if (greens == 5)      begin m_won = 1; m_phase = 3; end
      else if (m_row == 5)  begin m_lost = 1; m_phase = 4; end
      else                  begin m_row++; m_col = 0; m_phase = 1; end
   endtask

   function automatic logic [209:0] exp_disp();
      logic [209:0] d;
      d = '0;
      for (int r = 0; r < 6; r++)
         for (int c = 0; c < 5; c++)
            d[35*r + 7*c +: 7] = {2'(m_clr[r][c]), 5'(m_let[r][c])};
      return d;
   endfunction

   function automatic logic [9:0] dut_row_cols(input int r);
      logic [9:0] v;
      for (int c = 0; c < 5; c++) v[2*c +: 2] = bus.display[35*r + 7*c + 5 +: 2];
      return v;
   endfunction

   function automatic logic [24:0] word(input string s);
      logic [24:0] w;
      w = '0;
      for (int i = 0; i < 5; i++) w[5*i +: 5] = 5'(s[i] - 8'd65);
      return w;
   endfunction

   task automatic tick();
      @(posedge dclk);
      #1;
   endtask

   task automatic press(input int k);
      bus.key_valid = 1'b1;
      bus.key_code  = 5'(k);
      tick();
      bus.key_valid = 1'b0;
      m_key(k);
   endtask

   task automatic type_word(input string s);
      for (int i = 0; i < s.len(); i++) press(int'(s[i]) - 65);
   endtask

   task automatic start_game(input logic [24:0] sec);
      bus.new_game = 1'b1;
      bus.secret   = sec;
      tick();
      bus.new_game = 1'b0;
      m_new(sec);
   endtask

   task automatic finish_score(output int n, input bit noise);
      n = 0;
      while (bus.busy === 1'b1 && n < 40) begin
         if (noise) begin
            bus.key_valid = 1'($urandom_range(0, 1));
            bus.key_code  = 5'($urandom_range(0, 31));
         end
         tick();
         bus.key_valid = 1'b0;
         n++;
      end
      m_score();
   endtask

   task automatic test_reset();
      bus.new_game = 0; bus.secret = '0; bus.key_valid = 0; bus.key_code = '0;
      clr = 1'b1;
      tick(); tick();
      clr = 1'b0;
      m_clear_board(); m_phase = 0;
      n_checks++;
      if (bus.display !== RST_IMG) begin n_fail++;
         $display("FAIL reset_display got %h want %h", bus.display, RST_IMG); end
      n_checks++;
      if ({bus.busy, bus.won, bus.lost, bus.cur_row, bus.cur_col} !== 9'd0) begin n_fail++;
         $display("FAIL reset_flags got %b want 0", {bus.busy, bus.won, bus.lost, bus.cur_row, bus.cur_col}); end
      press(0); press(1); press(26);
      n_checks++;
      if (bus.display !== RST_IMG || bus.cur_col !== 3'd0 || bus.busy !== 1'b0) begin n_fail++;
         $display("FAIL idle_keys got col=%0d busy=%b disp=%h", bus.cur_col, bus.busy, bus.display); end
   endtask

   task automatic test_win();
      int n;
      logic [209:0] saved;
      start_game(word("CRANE"));
      type_word("CRANE");
      n_checks++;
      if (bus.display !== exp_disp() || bus.cur_col !== 3'd5) begin n_fail++;
         $display("FAIL win_typed got col=%0d disp=%h want %h", bus.cur_col, bus.display, exp_disp()); end
      press(26);
      n_checks++;
      if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL win_busy_start got %b want 1", bus.busy); end
      finish_score(n, 0);
      n_checks++;
      if (n != 11) begin n_fail++; $display("FAIL win_busy_len got %0d want 11", n); end
      n_checks++;
      if (dut_row_cols(0) !== 10'b01_01_01_01_01 || bus.won !== 1'b1 || bus.lost !== 1'b0) begin n_fail++;
         $display("FAIL win_row0 got cols=%b won=%b lost=%b want 0101010101 1 0", dut_row_cols(0), bus.won, bus.lost); end
      saved = bus.display;
      press(3);
      n_checks++;
      if (bus.display !== saved || bus.display !== exp_disp()) begin n_fail++;
         $display("FAIL win_frozen got %h want %h", bus.display, saved); end
   endtask

   task automatic test_dups();
      int n;
      start_game(word("ABBEY"));
      type_word("BABES"); press(26); finish_score(n, 0);
      n_checks++;
      if (dut_row_cols(0) !== 10'b00_01_01_10_10) begin n_fail++;
         $display("FAIL dups_babes got %b want 0001011010", dut_row_cols(0)); end
      type_word("BBBBB"); press(26); finish_score(n, 0);
      n_checks++;
      if (dut_row_cols(1) !== 10'b00_00_01_01_00) begin n_fail++;
         $display("FAIL dups_bbbbb got %b want 0000010100", dut_row_cols(1)); end
      n_checks++;
      if (bus.display !== exp_disp() || bus.cur_row !== 3'd2 || bus.cur_col !== 3'd0) begin n_fail++;
         $display("FAIL dups_board got row=%0d col=%0d disp=%h want %h", bus.cur_row, bus.cur_col, bus.display, exp_disp()); end
   endtask

   task automatic test_bounds();
      start_game(word("HELLO"));
      type_word("ABCDE"); press(5);
      n_checks++;
      if (bus.cur_col !== 3'd5 || bus.display !== exp_disp()) begin n_fail++;
         $display("FAIL bnd_sixth got col=%0d want 5", bus.cur_col); end
      press(27); press(26);
      n_checks++;
      if (bus.busy !== 1'b0 || bus.cur_col !== 3'd4) begin n_fail++;
         $display("FAIL bnd_enter4 got busy=%b col=%0d want 0 4", bus.busy, bus.cur_col); end
      press(27); press(27); press(27); press(27); press(27);
      n_checks++;
      if (bus.cur_col !== 3'd0 || bus.display !== RST_IMG) begin n_fail++;
         $display("FAIL bnd_back0 got col=%0d disp=%h", bus.cur_col, bus.display); end
      type_word("XYZ"); press(27);
      n_checks++;
      if (bus.cur_col !== 3'd2 || bus.display[14 +: 7] !== 7'h1A || bus.display !== exp_disp()) begin n_fail++;
         $display("FAIL bnd_back3 got col=%0d cell=%h want 2 1a", bus.cur_col, bus.display[14 +: 7]); end
   endtask

   task automatic test_lose();
      int n;
      logic [209:0] saved;
      start_game(word("CRANE"));
      for (int g = 0; g < 6; g++) begin
         type_word("ZZZZZ"); press(26); finish_score(n, 0);
         n_checks++;
         if (n != 11 || bus.display !== exp_disp()) begin n_fail++;
            $display("FAIL lose_guess%0d got busy_len=%0d disp=%h want 11 %h", g, n, bus.display, exp_disp()); end
      end
      n_checks++;
      if (bus.lost !== 1'b1 || bus.won !== 1'b0 || bus.cur_row !== 3'd5) begin n_fail++;
         $display("FAIL lose_flags got lost=%b won=%b row=%0d want 1 0 5", bus.lost, bus.won, bus.cur_row); end
      saved = bus.display;
      press(0); press(26);
      n_checks++;
      if (bus.display !== saved || bus.cur_row !== 3'd5 || bus.busy !== 1'b0) begin n_fail++;
         $display("FAIL lose_frozen got row=%0d busy=%b", bus.cur_row, bus.busy); end
   endtask

   task automatic test_abort();
      start_game(word("CRANE"));
      type_word("CRANE"); press(26);
      tick(); tick(); tick();
      bus.new_game = 1'b1; bus.secret = word("CRANE");
      tick();
      bus.new_game = 1'b0;
      m_new(word("CRANE"));
      n_checks++;
      if (bus.display !== RST_IMG || bus.busy !== 1'b0 || bus.cur_col !== 3'd0) begin n_fail++;
         $display("FAIL abort_ng got busy=%b col=%0d disp=%h", bus.busy, bus.cur_col, bus.display); end
      for (int i = 0; i < 15; i++) tick();
      n_checks++;
      if (bus.display !== RST_IMG || bus.won !== 1'b0) begin n_fail++;
         $display("FAIL abort_ng_late got won=%b disp=%h", bus.won, bus.display); end
      type_word("CRANE"); press(26);
      for (int i = 0; i < 6; i++) tick();
      #2 clr = 1'b1;
      #1;
      n_checks++;
      if (bus.display !== RST_IMG || bus.busy !== 1'b0 || bus.cur_col !== 3'd0) begin n_fail++;
         $display("FAIL abort_clr got busy=%b col=%0d disp=%h", bus.busy, bus.cur_col, bus.display); end
      clr = 1'b0;
      m_clear_board(); m_phase = 0;
      for (int i = 0; i < 15; i++) tick();
      press(4);
      n_checks++;
      if (bus.display !== RST_IMG || bus.cur_col !== 3'd0 || bus.won !== 1'b0) begin n_fail++;
         $display("FAIL abort_clr_idle got col=%0d won=%b disp=%h", bus.cur_col, bus.won, bus.display); end
   endtask

   task automatic test_random();
      int n, k, sel;
      logic [24:0] sec;
      for (int g = 0; g < 8; g++) begin
         sec = '0;
         for (int i = 0; i < 5; i++) sec[5*i +: 5] = 5'($urandom_range(0, 3));
         start_game(sec);
         for (int s = 0; s < 120 && m_phase < 3; s++) begin
            sel = int'($urandom_range(0, 99));
            if (sel < 65)      k = int'($urandom_range(0, 4));
            else if (sel < 78) k = 27;
            else if (sel < 95) k = 26;
            else               k = int'($urandom_range(28, 31));
            press(k);
            if (m_phase == 2) begin
               finish_score(n, 1);
               n_checks++;
               if (n != 11) begin n_fail++;
                  $display("FAIL rnd_busy_len game %0d got %0d want 11", g, n); end
            end
            n_checks++;
            if ({bus.display, bus.cur_row, bus.cur_col, bus.busy, bus.won, bus.lost} !==
                {exp_disp(), 3'(m_row), 3'(m_col), 1'b0, m_won, m_lost}) begin
               n_fail++;
               $display("FAIL rnd_state game %0d step %0d got row=%0d col=%0d busy=%b won=%b lost=%b disp=%h want row=%0d col=%0d won=%b lost=%b disp=%h",
                        g, s, bus.cur_row, bus.cur_col, bus.busy, bus.won, bus.lost, bus.display,
                        m_row, m_col, m_won, m_lost, exp_disp());
            end
         end
      end
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_win();
      test_dups();
      test_bounds();
      test_lose();
      test_abort();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
